// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-port round-robin CBus arbiter with burst-locked grants.
// Optional kseg0/kseg1 address folding: define CBUS_ADDR_TRANS_EN.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [N_PORTS],
  output cbus_resp_t iresps [N_PORTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_PORTS - 1);

  state_t           state_q, state_d;
  cbus_req_t        saved_req_q, saved_req_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic [IDX_W-1:0] pick;
  logic             any_valid;
  int               idx;

`ifdef CBUS_ADDR_TRANS_EN
  function automatic logic [31:0] xlat(input logic [31:0] a);
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101)
      return {3'b000, a[28:0]};
    return a;
  endfunction
`else
  function automatic logic [31:0] xlat(input logic [31:0] a);
    return a;
  endfunction
`endif

  // Scan from one past the previous winner, wrapping mod N_PORTS.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_PORTS)
        idx = idx - N_PORTS;
      if (!any_valid && ireqs[idx].valid) begin
        any_valid = 1'b1;
        pick      = IDX_W'(idx);
      end
    end
  end

  // Grant/release decisions; the request is latched once per grant.
  always_comb begin
    state_d      = state_q;
    saved_req_d  = saved_req_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d     = BUSY;
          sel_d       = pick;
          saved_req_d = ireqs[pick];
        end
      end
      BUSY: begin
        if (oresp.ready && oresp.last) begin
          state_d      = IDLE;
          last_grant_d = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      saved_req_q  <= '0;
      sel_q        <= '0;
      last_grant_q <= LastIdx;
    end else begin
      state_q      <= state_d;
      saved_req_q  <= saved_req_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Drive the registered request out; steer the response to the owner.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < N_PORTS; i++)
      iresps[i] = '0;
    if (state_q == BUSY) begin
      oreq       = saved_req_q;
      oreq.valid = 1'b1;
      oreq.addr  = xlat(saved_req_q.addr);
      for (int i = 0; i < N_PORTS; i++)
        if (IDX_W'(i) == sel_q)
          iresps[i] = oresp;
    end
  end

  // Indices must stay inside the port range for non-power-of-two N.
  a_sel_range: assert property (
    @(posedge clk) disable iff (reset)
    int'(sel_q) < N_PORTS && int'(last_grant_q) < N_PORTS
  );

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: scoreboard bench for cbus_rr_arbiter, N_PORTS=3.
// Grant order and latched request fields are checked against a queue.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [3:0]  len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   lastcnt[N];
  int   last_wait;

  cbus_rr_arbiter #(.N_PORTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .iresps(iresps),
    .oreq  (oreq),
    .oresp (oresp)
  );

  always #5 clk = ~clk;

  function automatic cbus_req_t mk(input int p, input logic [31:0] a,
                                   input logic [3:0] l);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.size     = 3'b010;
    r.addr     = a;
    r.data     = {24'h0, 8'(p)};
    r.len      = l;
    return r;
  endfunction

  function automatic logic [31:0] xlat(input logic [31:0] a);
`ifdef CBUS_ADDR_TRANS_EN
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101)
      return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  function automatic void push(input int p, input logic [31:0] a,
                               input logic [3:0] l);
    exp_t e;
    e.port = p;
    e.addr = a;
    e.len  = l;
    sb.push_back(e);
  endfunction

  // Wait for a grant, pop the expected one, feed len+1 beats, check bubble.
  task automatic serve(input bit drop, input bit mutate);
    exp_t      e;
    int        port;
    int        cyc;
    cbus_req_t snap;
    cyc = 0;
    @(negedge clk);
    while (oreq.valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    last_wait = cyc;
    checks++;
    if (oreq.valid !== 1'b1) begin
      errors++;
      $display("FAIL grant_timeout: oreq.valid=%b required 1", oreq.valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: unexpected grant data=%h", oreq.data);
      return;
    end
    e    = sb.pop_front();
    port = int'(oreq.data[7:0]);
    checks++;
    if (port != e.port) begin
      errors++;
      $display("FAIL grant_port: got %0d required %0d", port, e.port);
    end
    if (port >= N) return;
    checks++;
    if (oreq.addr !== e.addr) begin
      errors++;
      $display("FAIL oreq_addr: got %h required %h", oreq.addr, e.addr);
    end
    checks++;
    if (oreq.len !== e.len) begin
      errors++;
      $display("FAIL oreq_len: got %0d required %0d", oreq.len, e.len);
    end
    snap = oreq;
    for (int b = 0; b <= int'(e.len); b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == int'(e.len));
      oresp.data  = 32'hD000_0000 | 32'(b);
      #1;
      checks++;
      if (oreq !== snap) begin
        errors++;
        $display("FAIL oreq_stable: beat %0d got %h required %h",
                 b, oreq, snap);
      end
      checks++;
      if (iresps[port].ready !== 1'b1 ||
          iresps[port].last !== (b == int'(e.len)) ||
          iresps[port].data !== (32'hD000_0000 | 32'(b))) begin
        errors++;
        $display("FAIL iresp_owner: port %0d beat %0d got %h", port, b,
                 iresps[port]);
      end
      for (int i = 0; i < N; i++) begin
        if (i != port) begin
          checks++;
          if (iresps[i] !== '0) begin
            errors++;
            $display("FAIL iresp_other: port %0d got %h required 0",
                     i, iresps[i]);
          end
        end
      end
      if (iresps[port].last === 1'b1)
        lastcnt[port]++;
      if (mutate && b == 0)
        ireqs[port].addr = ireqs[port].addr ^ 32'h0000_0F00;
      @(negedge clk);
    end
    oresp = '0;
    checks++;
    if (oreq.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_bubble: oreq.valid=%b required 0", oreq.valid);
    end
    if (drop)
      ireqs[port].valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    oresp = '0;
    for (int p = 0; p < N; p++)
      ireqs[p] = mk(p, 32'h0000_1000 + 32'h100 * p, 4'd0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (oreq !== '0) begin
        errors++;
        $display("FAIL reset_oreq: got %h required 0", oreq);
      end
      for (int p = 0; p < N; p++) begin
        checks++;
        if (iresps[p] !== '0) begin
          errors++;
          $display("FAIL reset_iresp: port %0d got %h required 0",
                   p, iresps[p]);
        end
      end
    end
    reset = 1'b0;
    push(0, xlat(32'h0000_1000), 4'd0);
    serve(1'b1, 1'b0);
    checks++;
    if (last_wait != 0) begin
      errors++;
      $display("FAIL first_latency: waited %0d required 0", last_wait);
    end
    for (int p = 0; p < N; p++)
      ireqs[p].valid = 1'b0;
  endtask

  task automatic test_rotation();
    for (int p = 0; p < N; p++) begin
      ireqs[p]   = mk(p, 32'h0000_2000 + 32'h100 * p, 4'd0);
      lastcnt[p] = 0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push(0, 32'h0000_2000, 4'd0);
    push(1, 32'h0000_2100, 4'd0);
    push(2, 32'h0000_2200, 4'd0);
    push(0, 32'h0000_2000, 4'd0);
    repeat (3) serve(1'b0, 1'b0);
    for (int p = 0; p < N; p++) begin
      checks++;
      if (lastcnt[p] != 1) begin
        errors++;
        $display("FAIL round_last: port %0d got %0d required 1",
                 p, lastcnt[p]);
      end
    end
    serve(1'b1, 1'b0);
    for (int p = 0; p < N; p++)
      ireqs[p].valid = 1'b0;
  endtask

  task automatic test_burst();
    ireqs[0] = mk(0, 32'h0000_3000, 4'd0);
    ireqs[1] = mk(1, 32'h8000_0040, 4'd3);
    push(1, xlat(32'h8000_0040), 4'd3);
    push(0, xlat(32'h0000_3000), 4'd0);
    serve(1'b1, 1'b0);
    serve(1'b1, 1'b0);
    checks++;
    if (last_wait != 0) begin
      errors++;
      $display("FAIL back_to_back: waited %0d required 0", last_wait);
    end
  endtask

  task automatic test_addr_hold();
    ireqs[0] = mk(0, 32'h0000_4000, 4'd2);
    push(0, xlat(32'h0000_4000), 4'd2);
    serve(1'b1, 1'b1);
  endtask

  task automatic test_reset_busy();
    exp_t e;
    int   cyc;
    cyc      = 0;
    ireqs[2] = mk(2, 32'h0000_5000, 4'd1);
    push(2, 32'h0000_5000, 4'd1);
    @(negedge clk);
    while (oreq.valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (oreq.valid !== 1'b1) begin
      errors++;
      $display("FAIL rb_timeout: oreq.valid=%b required 1", oreq.valid);
    end
    e = sb.pop_front();
    checks++;
    if (int'(oreq.data[7:0]) != e.port) begin
      errors++;
      $display("FAIL rb_port: got %0d required %0d", oreq.data[7:0], e.port);
    end
    reset = 1'b1;
    oresp = '0;
    @(negedge clk);
    checks++;
    if (oreq !== '0) begin
      errors++;
      $display("FAIL rb_oreq: got %h required 0", oreq);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (iresps[p] !== '0) begin
        errors++;
        $display("FAIL rb_iresp: port %0d got %h required 0", p, iresps[p]);
      end
    end
    reset = 1'b0;
    for (int p = 0; p < N; p++)
      ireqs[p] = mk(p, 32'h0000_6000 + 32'h100 * p, 4'd0);
    push(0, 32'h0000_6000, 4'd0);
    serve(1'b1, 1'b0);
    for (int p = 0; p < N; p++)
      ireqs[p].valid = 1'b0;
  endtask

  task automatic test_addr_trans();
    ireqs[0] = mk(0, 32'hA000_1000, 4'd0);
    ireqs[1] = mk(1, 32'h1FC0_0000, 4'd0);
    push(1, 32'h1FC0_0000, 4'd0);
`ifdef CBUS_ADDR_TRANS_EN
    push(0, 32'h0000_1000, 4'd0);
`else
    push(0, 32'hA000_1000, 4'd0);
`endif
    serve(1'b1, 1'b0);
    serve(1'b1, 1'b0);
  endtask

  task automatic test_idle();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (oreq.valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: oreq.valid=%b required 0", oreq.valid);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d required 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    oresp = '0;
    for (int p = 0; p < N; p++)
      ireqs[p] = '0;
    test_reset();
    test_rotation();
    test_burst();
    test_addr_hold();
    test_reset_busy();
    test_addr_trans();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
